// File: rtl/fp16_pkg.sv
// Shared definitions for the binary16 multiplier: field widths, bias,
// special encodings and the packed operand layout.
package fp16_pkg;

  localparam int EXP_W  = 5;
  localparam int FRAC_W = 10;
  localparam int BIAS   = 15;

  localparam logic [15:0] QNAN    = 16'h7E00;
  localparam logic [15:0] POS_INF = 16'h7C00;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp16_t;

endpackage

// File: rtl/fp16_mul_core.sv
// Combinational binary16 multiply: classify, multiply significands,
// normalise, round to nearest even, then pack with FTZ/overflow handling.
module fp16_mul_core
  import fp16_pkg::*;
(
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [15:0] o_p
);

  localparam logic signed [7:0] BIAS_S = BIAS[7:0];

  fp16_t w_a;
  fp16_t w_b;
  logic  w_sign;
  logic  w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;

  logic [21:0]        w_sig_a;
  logic [21:0]        w_sig_b;
  logic [21:0]        w_prod;
  logic signed [7:0]  w_exp_sum;

  logic               w_norm;
  logic [FRAC_W-1:0]  w_frac;
  logic               w_guard;
  logic               w_sticky;
  logic               w_round_up;
  logic [FRAC_W:0]    w_frac_rnd;
  logic signed [7:0]  w_exp_fin;

  assign w_a    = i_a;
  assign w_b    = i_b;
  assign w_sign = w_a.sign ^ w_b.sign;

  // Zero covers subnormals too: they are flushed on input.
  assign w_a_zero = (w_a.exp == 5'd0);
  assign w_b_zero = (w_b.exp == 5'd0);
  assign w_a_inf  = (w_a.exp == 5'h1F) && (w_a.frac == 10'd0);
  assign w_b_inf  = (w_b.exp == 5'h1F) && (w_b.frac == 10'd0);
  assign w_a_nan  = (w_a.exp == 5'h1F) && (w_a.frac != 10'd0);
  assign w_b_nan  = (w_b.exp == 5'h1F) && (w_b.frac != 10'd0);

  assign w_sig_a   = {11'd0, 1'b1, w_a.frac};
  assign w_sig_b   = {11'd0, 1'b1, w_b.frac};
  assign w_prod    = w_sig_a * w_sig_b;
  assign w_exp_sum = $signed({3'b000, w_a.exp}) + $signed({3'b000, w_b.exp}) - BIAS_S;

  // Normalise the 22-bit product and derive fraction, guard and sticky.
  always_comb begin
    w_norm   = w_prod[21];
    w_frac   = 10'd0;
    w_guard  = 1'b0;
    w_sticky = 1'b0;
    if (w_norm) begin
      w_frac   = w_prod[20:11];
      w_guard  = w_prod[10];
      w_sticky = |w_prod[9:0];
    end else begin
      w_frac   = w_prod[19:10];
      w_guard  = w_prod[9];
      w_sticky = |w_prod[8:0];
    end
  end

  // Round to nearest even; a carry out of the fraction bumps the exponent.
  always_comb begin
    w_round_up = w_guard & (w_sticky | w_frac[0]);
    w_frac_rnd = {1'b0, w_frac} + {10'd0, w_round_up};
    w_exp_fin  = w_exp_sum
               + (w_norm        ? 8'sd1 : 8'sd0)
               + (w_frac_rnd[10] ? 8'sd1 : 8'sd0);
  end

  // Select the result by special-case priority, then range-check normals.
  always_comb begin
    o_p = 16'h0000;
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) begin
      o_p = QNAN;
    end else if (w_a_inf || w_b_inf) begin
      o_p = {w_sign, POS_INF[14:0]};
    end else if (w_a_zero || w_b_zero) begin
      o_p = {w_sign, 15'd0};
    end else if (w_exp_fin >= 8'sd31) begin
      o_p = {w_sign, POS_INF[14:0]};
    end else if (w_exp_fin <= 8'sd0) begin
      o_p = {w_sign, 15'd0};
    end else begin
      // A rounding carry leaves w_frac_rnd[9:0] at zero, as required.
      o_p = {w_sign, w_exp_fin[4:0], w_frac_rnd[9:0]};
    end
  end

endmodule

// File: rtl/fp16_mul.sv
// Binary16 multiplier top: combinational core plus one register stage
// for the product and the valid flag. Product holds when no valid input.
module fp16_mul
  import fp16_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  output logic [15:0] p
);

  logic [15:0] w_p;
  logic [15:0] r_p;
  logic        r_valid;

  fp16_mul_core u_core (
    .i_a (a),
    .i_b (b),
    .o_p (w_p)
  );

  // Output stage: capture product on valid input, track valid every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p     <= 16'h0000;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_p <= w_p;
      end
    end
  end

  assign p         = r_p;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_fp16_mul.sv
// Scoreboard bench for fp16_mul: every driven cycle pushes its expected
// output; the monitor pops and compares once the registered result appears.
module tb_fp16_mul;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic [15:0] p;

  typedef struct {
    logic        v;
    logic [15:0] p;
    string       tag;
  } sb_t;

  sb_t         sb_q[$];
  logic [15:0] last_exp;
  int          n_checks;
  int          n_pass;

  fp16_mul dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .p         (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] ia, input logic [15:0] ib,
                       input logic [15:0] exp, input string tag);
    sb_t it;
    @(posedge clk);
    #1;
    in_valid = v;
    a        = ia;
    b        = ib;
    it.v     = v;
    it.p     = exp;
    it.tag   = tag;
    sb_q.push_back(it);
  endtask

  // Monitor: the oldest queued entry belongs to the edge just taken.
  always @(negedge clk) begin
    if (!rst && sb_q.size() >= 2) begin
      sb_t it;
      it = sb_q.pop_front();
      check16({it.tag, "_valid"}, {15'd0, out_valid}, {15'd0, it.v});
      if (it.v) begin
        check16(it.tag, p, it.p);
        last_exp = it.p;
      end else begin
        check16({it.tag, "_hold"}, p, last_exp);
      end
    end
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    last_exp = 16'h0000;
    in_valid = 1'b0;
    a        = 16'h0000;
    b        = 16'h0000;
    rst      = 1'b1;
    #1;
    check16("por_p", p, 16'h0000);
    check16("por_valid", {15'd0, out_valid}, 16'h0000);
    @(posedge clk);
    #3 rst = 1'b0;

    // Get a nonzero product registered, then reset mid-stream.
    drive(1'b1, 16'h3C00, 16'h4000, 16'h4000, "pre_1x2");
    drive(1'b1, 16'hC500, 16'hC500, 16'h4E40, "pre_m5xm5");
    #1 rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check16("rst_async_p", p, 16'h0000);
    check16("rst_async_valid", {15'd0, out_valid}, 16'h0000);
    sb_q.delete();
    last_exp = 16'h0000;
    @(posedge clk);
    #1;
    check16("rst_hold_p", p, 16'h0000);
    @(posedge clk);
    #3 rst = 1'b0;

    // Back-to-back valid operands, one per cycle.
    drive(1'b1, 16'h3C00, 16'h4000, 16'h4000, "one_x_two");
    drive(1'b1, 16'hC500, 16'hC500, 16'h4E40, "m5_x_m5");
    drive(1'b1, 16'h3C00, 16'h3C00, 16'h3C00, "one_x_one");
    drive(1'b1, 16'h3C01, 16'h3C01, 16'h3C02, "rnd_down");
    drive(1'b1, 16'h3E00, 16'h3C01, 16'h3E02, "rnd_tie_even");
    drive(1'b1, 16'h7BFF, 16'h4000, 16'h7C00, "overflow");
    drive(1'b1, 16'h0400, 16'h0400, 16'h0000, "underflow_ftz");
    drive(1'b1, 16'h0200, 16'h0200, 16'h0000, "subnorm_daz");
    drive(1'b1, 16'hC500, 16'h0000, 16'h8000, "neg_zero");
    drive(1'b1, 16'h7C00, 16'h3C00, 16'h7C00, "inf_x_one");
    drive(1'b1, 16'hFC00, 16'h3C00, 16'hFC00, "ninf_x_one");
    drive(1'b1, 16'h7C00, 16'h0000, 16'h7E00, "inf_x_zero");
    drive(1'b1, 16'h7E01, 16'h3C00, 16'h7E00, "nan_in");
    drive(1'b1, 16'hBC00, 16'h4200, 16'hC200, "m1_x_3");
    drive(1'b1, 16'h3FFF, 16'h3FFF, 16'h43FE, "near_two_sq");
    drive(1'b1, 16'h3FFF, 16'h4000, 16'h43FF, "x_two_exact");

    // Idle cycles with changing operands: product must hold.
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
            16'h0000, "idle");
    end
    drive(1'b1, 16'h4000, 16'h4200, 16'h4600, "two_x_three");
    drive(1'b0, 16'h7E00, 16'h7E00, 16'h0000, "idle_after");
    drive(1'b0, 16'h1234, 16'h5678, 16'h0000, "idle_flush");
    @(posedge clk);
    @(negedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fp16_mul.md
Name: fp16_mul

Overview:
- Single-cycle-registered IEEE 754 binary16 (half-precision) floating-point multiplier.
- Takes two 16-bit operands laid out as sign[15], exponent[14:10] (bias 15) and fraction[9:0].
- Produces the registered product.
- Used as a leaf arithmetic unit in the datapath; no stalls, a new operand pair is accepted every cycle.

Parameters:
- EXP_W, 5, exponent field width (fixed for binary16; not overridable in practice).
- FRAC_W, 10, fraction field width.
- BIAS, 15, exponent bias.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands valid this cycle.
- a  input  16  operand A (binary16).
- b  input  16  operand B (binary16).
- out_valid  output  1  registered copy of in_valid.
- p  output  16  registered product (binary16).

Interface note: one clock; reset is asynchronous and active-high.

Behaviour:
- Reset: while rst is high, p=16'h0000 and out_valid=0, immediately and independent of clk.
- Latency: exactly 1 cycle.
  - On each rising clk edge with rst low, out_valid<=in_valid.
  - When in_valid=1, p<=f(a,b); when in_valid=0, p holds its value.
- Sign: result sign = a[15] XOR b[15], for every class including zero, inf and NaN (except the canonical NaN).
- Classification per operand:
  - exp=0 is zero. Subnormals are flushed to zero on input (DAZ).
  - exp=31, frac=0 is infinity.
  - exp=31, frac!=0 is NaN.
- Special cases, in priority order:
  - any NaN, or inf×zero → canonical NaN 16'h7E00 (sign 0).
  - inf×finite or inf×inf → signed infinity {s,5'h1F,10'h0}.
  - zero×finite → signed zero {s,15'h0}.
- Normal path:
  - Significands {1,frac} 11b × 11b → 22-bit product.
  - Biased exponent = ea+eb−15, computed in at least 7-bit signed arithmetic.
  - If product[21]=1: shift right 1 and exponent+1.
- Rounding: round-to-nearest-even using guard bit plus sticky (OR of all lower bits).
  - A round-up carry out of the fraction renormalises: fraction=0, exponent+1.
- Overflow: final biased exponent ≥31 → signed infinity.
- Underflow: final biased exponent ≤0 → signed zero (FTZ; no subnormal outputs).
- No exception flags, no alternate rounding modes.
- Simultaneous rst and clk edge: reset wins.

Decomposition:
- Shared package fp16_pkg holds:
  - constants EXP_W, FRAC_W, BIAS, QNAN=16'h7E00, POS_INF=16'h7C00;
  - a packed struct typedef {sign, exp, frac}.
- One combinational sub-module fp16_mul_core (classify, multiply, normalise, round, pack).
- Top fp16_mul instantiates the core and adds the output register and the valid flop.

Test Plan:
- Reset: assert rst mid-stream → p=16'h0000 and out_valid=0 without waiting for a clock edge; deassert, then 3C00×4000 (1.0×2.0) → 4000 one cycle later, out_valid=1.
- Exact normals:
  - C500×C500 (−5×−5) → 4E40 (25).
  - 3C00×3C00 → 3C00.
- Rounding:
  - 3C01×3C01 → 3C02 (below half ulp, rounds down).
  - 3E00×3C01 → 3E02 (exact tie, rounds to even, i.e. up).
- Limits:
  - 7BFF×4000 → 7C00 (overflow).
  - 0400×0400 → 0000 (underflow FTZ).
  - 0200×0200 → 0000 (subnormal inputs flushed).
- Specials:
  - C500×0000 → 8000.
  - 7C00×3C00 → 7C00.
  - FC00×3C00 → FC00.
  - 7C00×0000 → 7E00.
  - 7E01×3C00 → 7E00.
- Valid/hold: in_valid=0 with changing a/b → p unchanged and out_valid=0; back-to-back valid pairs every cycle → one result per cycle in order.
